// File: rtl/mul_div_if.sv
// Bus between the MIPS controller and the multiply/divide unit.
// The controller (master) drives the request; the unit (slave) returns
// status and the HI/LO registers.
interface mul_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, funct, a, b,
                   input  busy, done, dz, hi, lo);
   modport slave  (input  start, funct, a, b,
                   output busy, done, dz, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// mult/multu use radix-2 shift-add, div/divu use restoring division, one bit
// per cycle on magnitudes; signs are applied in a final FIX cycle.
// mthi/mtlo write HI/LO in a single cycle while idle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic     clk_i,
   input  logic     reset_i,
   mul_div_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend/quotient bits}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;       // |multiplicand| or |divisor|
   logic               is_div_q, is_div_d;
   logic               negx_q, negx_d;     // negate product / quotient
   logic               negr_q, negr_d;     // negate remainder (dividend sign)
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   diff;
   logic               ge;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   logic               is_md, sgn;
   logic [WIDTH-1:0]   a_abs, b_abs;

   // One iteration step of each algorithm plus the final sign-corrected results.
   always_comb begin
      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next = {add_sum, acc_q[WIDTH-1:1]};
      // Remainder can exceed WIDTH bits only transiently after the shift.
      trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      ge       = (trial >= {1'b0, opb_q});
      diff     = trial[WIDTH-1:0] - opb_q;
      div_next = {(ge ? diff : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
      prod_fix = negx_q ? -acc_q : acc_q;
      quo_fix  = negx_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state and register-update decisions for the IDLE/RUN/FIX sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      negx_d   = negx_q;
      negr_d   = negr_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      is_md    = (bus.funct == F_MULT) || (bus.funct == F_MULTU) ||
                 (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
      sgn      = ~bus.funct[0];
      a_abs    = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_abs    = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (is_md) begin
                  is_div_d = bus.funct[1];
                  opb_d    = b_abs;
                  cnt_d    = CW'(WIDTH - 1);
                  negx_d   = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  negr_d   = sgn & bus.a[WIDTH-1];
                  dz_d     = 1'b0;
                  acc_d    = {{WIDTH{1'b0}}, a_abs};
                  state_d  = RUN;
                  if (bus.funct[1] && (bus.b == '0)) begin
                     // Divide by zero: preload the fixed result and skip RUN.
                     acc_d   = {bus.a, {WIDTH{1'b1}}};
                     dz_d    = 1'b1;
                     state_d = FIX;
                  end
               end else if (bus.funct == F_MTHI) begin
                  hi_d = bus.a;
               end else if (bus.funct == F_MTLO) begin
                  lo_d = bus.a;
               end
            end
         end
         RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (dz_q) begin
               hi_d = acc_q[2*WIDTH-1:WIDTH];
               lo_d = acc_q[WIDTH-1:0];
            end else if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         negx_q   <= 1'b0;
         negr_q   <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
         negx_q   <= negx_d;
         negr_q   <= negr_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dz   = dz_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, parametrised-width multiply/divide unit for the MIPS datapath. It executes mult, multu, div and divu over multiple cycles and holds the results in internal HI/LO registers. It also services the single-cycle mthi/mtlo writes. It sits beside the ALU: the controller raises `start` with the R-type funct and waits on `busy`/`done`, and mfhi/mflo read the `hi`/`lo` outputs directly.

## Interface
- WIDTH, 32, operand and HI/LO register width (≥ 4)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when idle
- funct  in  6  R-type funct: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo
- a  in  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo data)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  high while a mult/div is in flight
- done  out  1  one-cycle pulse when HI/LO are updated by mult/div
- dz  out  1  divide-by-zero flag, valid with `done`, held until next accepted start
- hi  out  WIDTH  HI register (mult: upper product; div: remainder)
- lo  out  WIDTH  LO register (mult: lower product; div: quotient)

## Operation
- States: IDLE, RUN, FIX.
- In IDLE with start=1 and funct a mult/div code:
  - latch |a|, |b| (signed ops) or a, b (unsigned ops)
  - latch the sign flags, load the cycle counter with WIDTH−1, clear dz, go to RUN.
- mthi/mtlo with start=1 in IDLE: write `a` into HI/LO at that edge. State stays IDLE; no busy, no done.
- Any other funct with start=1: ignored, no state change.
- start while busy: ignored. a, b and funct changes while busy have no effect.
- RUN, multiply: radix-2 shift-add over a 2·WIDTH-bit accumulator, one bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN lasts exactly WIDTH cycles (counter reaches 0), then the unit goes to FIX.
- FIX:
  - Apply sign correction. Signed product is negated if the operand signs differ. Signed quotient is negated if the signs differ. Remainder takes the sign of the dividend, so division truncates toward zero.
  - Write HI/LO, pulse done, return to IDLE.
- Divide by zero (b == 0 at start, div or divu): skip RUN and go straight to FIX. Result is HI = a (original), LO = all ones, dz = 1.
- Overflow: most-negative ÷ −1 gives LO = most-negative and HI = 0 (wraps); this is not flagged.
- Arithmetic is internally WIDTH+1 bits for the divider subtract and 2·WIDTH bits for the product. All results are truncated to WIDTH per register.

## Timing
- Reset (asynchronous, any time, including mid-operation) forces:
  - state = IDLE
  - busy = 0, done = 0, dz = 0
  - hi = 0, lo = 0, counter = 0
  - The in-flight operation is discarded.
- Edge E0 accepts start. busy = 1 from after E0 until after edge E0+WIDTH+1.
- At edge E0+WIDTH+1, hi/lo are written, done = 1 for that one cycle, and busy = 0. Latency is WIDTH+1 clocks (33 for WIDTH=32).
- Divide by zero: E0 → FIX. At E0+1, hi/lo are written and done = 1. busy is high for one cycle.
- A new start may be accepted in the same cycle done is high (back-to-back). The unit is IDLE then.
- hi/lo hold their value between operations and change only at FIX or at an mthi/mtlo edge.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- mult a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; then div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu a=7, b=2 → lo=3, hi=1.
- divu a=0x1234, b=0 → done 1 cycle after the start edge, dz=1, hi=0x00001234, lo=0xFFFFFFFF; next accepted start clears dz.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, dz=0.
- start a multu, pulse start with divu and change a/b at cycle 10 → ignored; original result correct. Then back-to-back start in the done cycle → accepted.
- Assert reset at cycle 15 of a mult → busy=0, done never pulses, hi=lo=0. Then mthi a=0xA5A5A5A5 → hi=0xA5A5A5A5 next cycle, no busy, no done.
